// File: rtl/cskip_pkg.sv
// Shared helpers for the pipelined carry-skip adder.
// Segment count/width functions and default sizes.
package cskip_pkg;

    localparam int WIDTH_DEF = 26;
    localparam int SEG_DEF   = 8;
    localparam int SKIP_DEF  = 4;

    function automatic int nseg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // Last segment carries the remainder bits.
    function automatic int seg_w(input int k, input int width, input int seg);
        int rem;
        rem = width - k * seg;
        return (rem < seg) ? rem : seg;
    endfunction

endpackage

// File: rtl/cskip_segment.sv
// Combinational carry-skip adder for one pipeline segment.
// Ports: a, b (W bits), ci in; s (W bits), co, c_msb (carry into bit W-1) out.
module cskip_segment
    import cskip_pkg::*;
#(
    parameter int W    = 8,
    parameter int SKIP = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic carry;
    logic bcin;
    logic prop;

    // Ripple inside each block; block carry-out bypasses the ripple
    // when every bit of the block propagates.
    always_comb begin
        s     = '0;
        c_msb = ci;
        carry = ci;
        bcin  = ci;
        prop  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (i % SKIP == 0) begin
                bcin = carry;
                prop = 1'b1;
            end
            prop = prop & (a[i] ^ b[i]);
            s[i] = a[i] ^ b[i] ^ carry;
            if (i == W - 1) c_msb = carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            if ((i % SKIP == SKIP - 1) || (i == W - 1))
                carry = prop ? bcin : carry;
        end
        co = carry;
    end

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder: one segment per stage, valid/ready on both sides.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b, cin,
// out_valid/out_ready, sum, cout; ovf only when CSKIP_OVF_EN is defined.
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG   = SEG_DEF,
    parameter int SKIP  = SKIP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSKIP_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (SKIP < 1 || SKIP > SEG || WIDTH < 1) begin : g_bad_cfg
        $error("cskip_adder_pipe: illegal WIDTH/SEG/SKIP");
    end

    logic adv;

    logic             v_q [NSEG];
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic             c_q [NSEG];

    // Global stall: every stage moves together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

`ifdef CSKIP_OVF_EN
    logic cm_last;
    logic co_last;
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int SW = seg_w(k, WIDTH, SEG);

        logic             sv;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic             sc;
        logic [SW-1:0]    seg_s;
        logic             seg_co;
        logic             seg_cm;
        logic             unused_cm;
        logic [WIDTH-1:0] nxt_s;

        if (k == 0) begin : g_src
            assign sv = in_valid;
            assign sa = a;
            assign sb = b;
            assign ss = '0;
            assign sc = cin;
        end else begin : g_src
            assign sv = v_q[k-1];
            assign sa = a_q[k-1];
            assign sb = b_q[k-1];
            assign ss = s_q[k-1];
            assign sc = c_q[k-1];
        end

        cskip_segment #(
            .W    (SW),
            .SKIP (SKIP)
        ) u_seg (
            .a     (sa[LO +: SW]),
            .b     (sb[LO +: SW]),
            .ci    (sc),
            .s     (seg_s),
            .co    (seg_co),
            .c_msb (seg_cm)
        );

        assign unused_cm = seg_cm;

`ifdef CSKIP_OVF_EN
        if (k == NSEG - 1) begin : g_last
            assign cm_last = seg_cm;
            assign co_last = seg_co;
        end
`endif

        always_comb begin
            nxt_s            = ss;
            nxt_s[LO +: SW]  = seg_s;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (adv) begin
                v_q[k] <= sv;
                a_q[k] <= sa;
                b_q[k] <= sb;
                s_q[k] <= nxt_s;
                c_q[k] <= seg_co;
            end
        end
    end

    // Operand copies out of the final stage have no consumer.
    logic unused_ab;
    assign unused_ab = ^{a_q[NSEG-1], b_q[NSEG-1]};

    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];

`ifdef CSKIP_OVF_EN
    // Signed overflow registered alongside the final sum stage.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (adv)
            ovf <= cm_last ^ co_last;
    end
`endif

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Scoreboard bench for cskip_adder_pipe: (26,8,4) and (5,8,3) instances.
// Directed vectors, backpressure, mid-flight reset, random traffic.
module tb_cskip_adder_pipe;

    localparam int W   = 26;
    localparam int NS  = 4;
    localparam int W2  = 5;
    localparam int NS2 = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  ta = '0;
    logic [W-1:0]  tb = '0;
    logic          tcin = 1'b0;

    logic          in_ready, out_valid, cout;
    logic [W-1:0]  sum;
    logic          in_ready2, out_valid2, cout2;
    logic [W2-1:0] sum2;
`ifdef CSKIP_OVF_EN
    logic          ovf, ovf2;
`endif

    int total = 0;
    int bad   = 0;
    int adv_cnt  = 0;
    int adv2_cnt = 0;
    int last_wait = 0;

    logic [W-1:0]  exp_s = '0;
    logic          exp_c = 1'b0;
    logic [W2:0]   g2;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t e;
    exp_t e2;

    always #5 clk = ~clk;

    cskip_adder_pipe #(.WIDTH(W), .SEG(8), .SKIP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (ta),
        .b         (tb),
        .cin       (tcin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSKIP_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    cskip_adder_pipe #(.WIDTH(W2), .SEG(8), .SKIP(3)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (ta[W2-1:0]),
        .b         (tb[W2-1:0]),
        .cin       (tcin),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .sum       (sum2),
        .cout      (cout2)
`ifdef CSKIP_OVF_EN
       ,.ovf       (ovf2)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && (!out_valid || out_ready)) adv_cnt++;
        if (!rst && (!out_valid2 || out_ready)) adv2_cnt++;
    end

    // Stimulus side of the scoreboard: push expectation on every accept.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            q2.delete();
        end else begin
            if (in_valid && in_ready) begin
                e.s = exp_s;
                e.c = exp_c;
                e.o = (ta[W-1] == tb[W-1]) && (exp_s[W-1] != ta[W-1]);
                e.t = adv_cnt;
                q.push_back(e);
            end
            if (in_valid && in_ready2) begin
                g2 = {1'b0, ta[W2-1:0]} + {1'b0, tb[W2-1:0]} + {{W2{1'b0}}, tcin};
                e2.s = '0;
                e2.s[W2-1:0] = g2[W2-1:0];
                e2.c = g2[W2];
                e2.o = (ta[W2-1] == tb[W2-1]) && (g2[W2-1] != ta[W2-1]);
                e2.t = adv2_cnt;
                q2.push_back(e2);
            end
        end
    end

    // Response side: compare whatever the DUTs present.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("sum", sum, q[0].s);
                    chk("cout", cout, q[0].c);
`ifdef CSKIP_OVF_EN
                    chk("ovf", ovf, q[0].o);
`endif
                    if (out_ready) begin
                        chk("latency", adv_cnt - q[0].t, NS);
                        void'(q.pop_front());
                    end
                end
            end
            if (out_valid2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_out2", 1, 0);
                end else begin
                    chk("sum2", sum2, q2[0].s[W2-1:0]);
                    chk("cout2", cout2, q2[0].c);
`ifdef CSKIP_OVF_EN
                    chk("ovf2", ovf2, q2[0].o);
`endif
                    if (out_ready) begin
                        chk("latency2", adv2_cnt - q2[0].t, NS2);
                        void'(q2.pop_front());
                    end
                end
            end
        end
    end

    // Present one beat and hold it until the wide instance takes it.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] es,
                         input logic ec);
        int n;
        ta = x;
        tb = y;
        tcin = c;
        exp_s = es;
        exp_c = ec;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1, 0);
        last_wait = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_gold(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c);
        logic [W:0] g;
        g = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        issue(x, y, c, g[W-1:0], g[W]);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic pend;
        logic acc;
        logic [W:0] g;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid2", out_valid2, 0);
`ifdef CSKIP_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry ripples through every segment; exactly four cycles.
        issue(26'h3FFFFFF, 26'h0, 1'b1, 26'h0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("lat_early", out_valid, 0);
        end
        @(negedge clk);
        chk("lat_exact", out_valid, 1);
        @(negedge clk);
        chk("one_cycle", out_valid, 0);
        @(posedge clk);
        #1;

        issue(26'd1000000, 26'd2345678, 1'b0, 26'd3345678, 1'b0);
        drain();

        // Six back-to-back beats, each taken on the first cycle.
        issue(26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 26'h3FFFFFF, 1'b1);
        chk("b2b_ready", last_wait, 0);
        issue(26'h2AAAAAA, 26'h1555555, 1'b0, 26'h3FFFFFF, 1'b0);
        chk("b2b_ready", last_wait, 0);
        issue(26'h2AAAAAA, 26'h1555555, 1'b1, 26'h0000000, 1'b1);
        chk("b2b_ready", last_wait, 0);
        issue(26'h00000FF, 26'h0000001, 1'b0, 26'h0000100, 1'b0);
        chk("b2b_ready", last_wait, 0);
        issue(26'h0FFFFFF, 26'h0000001, 1'b0, 26'h1000000, 1'b0);
        chk("b2b_ready", last_wait, 0);
        issue(26'h2000000, 26'h2000000, 1'b0, 26'h0000000, 1'b1);
        chk("b2b_ready", last_wait, 0);
        drain();

        // Largest positive plus one: signed overflow, no carry.
        issue(26'h1FFFFFF, 26'h0000001, 1'b0, 26'h2000000, 1'b0);
        drain();

        // Fill, then stall three cycles.
        issue(26'h1, 26'h2, 1'b0, 26'h3, 1'b0);
        issue(26'h10, 26'h20, 1'b1, 26'h31, 1'b0);
        issue(26'hFFFF, 26'h1, 1'b0, 26'h10000, 1'b0);
        issue(26'h3FFFFFE, 26'h1, 1'b1, 26'h0, 1'b1);
        out_ready = 1'b0;
        ta = 26'h5;
        tb = 26'h5;
        tcin = 1'b0;
        exp_s = 26'hA;
        exp_c = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(26'h5, 26'h5, 1'b0, 26'hA, 1'b0);
        drain();

        // Reset with two beats in flight.
        issue(26'h7, 26'h8, 1'b0, 26'hF, 1'b0);
        issue(26'h100, 26'h200, 1'b0, 26'h300, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_flush", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(26'h2, 26'h3, 1'b0, 26'h5, 1'b0);
        drain();

        // Random traffic with random backpressure.
        pend = 1'b0;
        repeat (3000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                ta = W'($urandom);
                tb = W'($urandom);
                tcin = 1'($urandom);
                g = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
                exp_s = g[W-1:0];
                exp_c = g[W];
                in_valid = 1'b1;
                pend = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                pend = 1'b0;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        issue_gold(26'h3FFFFFF, 26'h3FFFFFF, 1'b0);

        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
